// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR command issuer: FSM encoding, request type,
// switch bit assignments and the default burst length.
package ddr_pkg;

  localparam int DEFAULT_BURST_LENGTH = 2;

  localparam int SW_LOAD_HI  = 0;
  localparam int SW_LOAD_LO  = 1;
  localparam int SW_WRITE    = 2;
  localparam int SW_READ     = 3;
  localparam int SW_SHOW_HI  = 4;
  localparam int SW_SHOW_LO  = 5;
  localparam int SW_LOAD_ROW = 6;
  localparam int SW_SPARE    = 7;
  localparam int SW_COUNT    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/sw_debounce.sv
// One switch input: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          settled;

  // The new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  assign settled = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // which is what makes the two synchronizer stages a real shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (settled) begin
        level <= sync[1];
        pulse <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_issuer.sv
// Switch-driven front end for a DDR SDRAM controller: loads a data word and row
// from the DIP switches, issues single write/read requests and shows read data.
module ddr_cmd_issuer
  import ddr_pkg::*;
#(
  parameter int BURST_LENGTH    = DEFAULT_BURST_LENGTH,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                       CLK_100M,
  input  logic                       RST,
  input  logic [7:0]                 Switch,
  input  logic [7:0]                 DPSwitch,
  input  logic                       BUSY,
  input  logic [16*BURST_LENGTH-1:0] RD_DATA,
  output logic                       WRITE,
  output logic                       READ,
  output logic [16*BURST_LENGTH-1:0] WR_DATA,
  output logic                       WR_OE,
  output logic [1:0]                 BA_IN,
  output logic [12:0]                ADDR_ROW_IN,
  output logic [9:0]                 ADDR_COL_IN,
  output logic [3:0]                 WRITE_LENGTH,
  output logic [7:0]                 LED,
  output logic                       ERR
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  logic [SW_COUNT-1:0] sw_level;
  logic [SW_COUNT-1:0] sw_pulse;

  for (genvar i = 0; i < SW_COUNT; i++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (CLK_100M),
      .rst   (RST),
      .din   (Switch[i]),
      .level (sw_level[i]),
      .pulse (sw_pulse[i])
    );
  end

  logic unused_inputs;
  assign unused_inputs = ^{sw_level, sw_pulse[SW_SPARE], RD_DATA};

  logic [15:0]   data_word;
  logic [7:0]    row_byte;
  logic [15:0]   rd_word;
  logic [7:0]    led_q;
  logic [15:0]   issue_word;
  logic [7:0]    issue_row;
  state_t        state;
  op_t           op;
  logic [AW-1:0] ack_cnt;
  logic          write_q;
  logic          read_q;
  logic          wr_oe_q;
  logic          err_q;

  // Switch-loaded registers update in any FSM state.
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      data_word <= '0;
      row_byte  <= '0;
      led_q     <= '0;
    end else begin
      if (sw_pulse[SW_LOAD_HI])  data_word[15:8] <= DPSwitch;
      if (sw_pulse[SW_LOAD_LO])  data_word[7:0]  <= DPSwitch;
      if (sw_pulse[SW_LOAD_ROW]) row_byte        <= DPSwitch;
      if (sw_pulse[SW_SHOW_HI])      led_q <= rd_word[15:8];
      else if (sw_pulse[SW_SHOW_LO]) led_q <= rd_word[7:0];
    end
  end

  // Data and row are snapshotted at issue so later loads cannot disturb a live request.
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      state      <= IDLE;
      op         <= OP_WR;
      ack_cnt    <= '0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      wr_oe_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_word    <= '0;
      issue_word <= '0;
      issue_row  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_cnt <= '0;
          if (sw_pulse[SW_WRITE]) begin
            state      <= ISSUE;
            op         <= OP_WR;
            write_q    <= 1'b1;
            wr_oe_q    <= 1'b1;
            issue_word <= data_word;
            issue_row  <= row_byte;
          end else if (sw_pulse[SW_READ]) begin
            state      <= ISSUE;
            op         <= OP_RD;
            read_q     <= 1'b1;
            issue_word <= data_word;
            issue_row  <= row_byte;
          end
        end
        ISSUE: begin
          state   <= WAIT_ACK;
          ack_cnt <= ack_cnt + AW'(1);
        end
        WAIT_ACK: begin
          // ack_cnt counts request-high cycles; the request is held ACK_TIMEOUT cycles at most.
          if (BUSY) begin
            state   <= WAIT_DONE;
            write_q <= 1'b0;
            read_q  <= 1'b0;
          end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            state   <= IDLE;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            wr_oe_q <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end
        WAIT_DONE: begin
          if (!BUSY) begin
            state   <= IDLE;
            wr_oe_q <= 1'b0;
            err_q   <= 1'b0;
            if (op == OP_RD) rd_word <= RD_DATA[15:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign WRITE        = write_q;
  assign READ         = read_q;
  assign WR_OE        = wr_oe_q;
  assign WR_DATA      = {BURST_LENGTH{issue_word}};
  assign BA_IN        = 2'b00;
  assign ADDR_ROW_IN  = {5'b0, issue_row};
  assign ADDR_COL_IN  = '0;
  assign WRITE_LENGTH = 4'd1;
  assign LED          = led_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Scoreboard bench: directed scenarios plus random operations against a
// behavioural model; a negedge monitor checks every request the DUT issues.
module tb_ddr_cmd_issuer;
  import ddr_pkg::*;

  localparam int BL = 2;
  localparam int DB = 4;
  localparam int AT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    sw;
  logic [7:0]    dp;
  logic          busy;
  logic [31:0]   rd_data;
  logic          write_o, read_o, wr_oe;
  logic [31:0]   wr_data;
  logic [1:0]    ba;
  logic [12:0]   row_o;
  logic [9:0]    col_o;
  logic [3:0]    wlen;
  logic [7:0]    led;
  logic          err;

  ddr_cmd_issuer #(.BURST_LENGTH(BL), .DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(AT)) dut (
    .CLK_100M     (clk),
    .RST          (rst),
    .Switch       (sw),
    .DPSwitch     (dp),
    .BUSY         (busy),
    .RD_DATA      (rd_data),
    .WRITE        (write_o),
    .READ         (read_o),
    .WR_DATA      (wr_data),
    .WR_OE        (wr_oe),
    .BA_IN        (ba),
    .ADDR_ROW_IN  (row_o),
    .ADDR_COL_IN  (col_o),
    .WRITE_LENGTH (wlen),
    .LED          (led),
    .ERR          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected request: kind, data word, row and how many cycles it stays high.
  typedef struct {
    bit          is_wr;
    logic [15:0] word;
    logic [7:0]  row;
    int          width;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [15:0] m_data = '0;
  logic [7:0]  m_row  = '0;
  logic [15:0] m_rd   = '0;
  logic [7:0]  m_led  = '0;
  logic        m_err  = 1'b0;

  // Memory-controller model knobs; latency 0 means it never answers.
  int          mdl_lat  = 3;
  int          mdl_busy = 10;
  logic [15:0] mdl_rd   = '0;
  int          busy_done = 0;

  initial begin
    busy    = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if ((write_o || read_o) && !rst) begin
        if (mdl_lat == 0) begin
          for (int i = 0; i < 4 * AT && (write_o || read_o); i++) @(negedge clk);
        end else begin
          repeat (mdl_lat) @(posedge clk);
          #1 busy = 1'b1;
          repeat (mdl_busy) @(posedge clk);
          #1;
          rd_data   = {16'($urandom), mdl_rd};
          busy      = 1'b0;
          busy_done++;
        end
      end
    end
  end

  // Monitor: pops an expectation on each request rise, checks width on its fall.
  int   falls = 0;
  bit   req_prev = 1'b0;
  bit   have_cur = 1'b0;
  bit   both_seen = 1'b0;
  int   width = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (write_o && read_o) both_seen = 1'b1;
    if ((write_o || read_o) && !req_prev) begin
      width = 1;
      check("req_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        cur      = exp_q.pop_front();
        have_cur = 1'b1;
        check("req_is_write", 32'(write_o), 32'(cur.is_wr));
        check("wr_data",      wr_data,      {BL{cur.word}});
        check("addr_row",     32'(row_o),   {24'b0, cur.row});
        check("wr_oe_at_req", 32'(wr_oe),   32'(cur.is_wr));
      end else begin
        have_cur = 1'b0;
      end
    end else if ((write_o || read_o) && req_prev) begin
      width++;
    end else if (!(write_o || read_o) && req_prev) begin
      falls++;
      if (have_cur) check("req_width", 32'(width), 32'(cur.width));
      have_cur = 1'b0;
    end
    req_prev = write_o || read_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    sw[idx] = 1'b1;
    tick(DB + 6);
    sw[idx] = 1'b0;
    tick(DB + 6);
  endtask

  task automatic load(input int idx, input logic [7:0] val);
    dp = val;
    press(idx);
    if (idx == SW_LOAD_HI)  m_data[15:8] = val;
    if (idx == SW_LOAD_LO)  m_data[7:0]  = val;
    if (idx == SW_LOAD_ROW) m_row        = val;
  endtask

  task automatic show(input int idx);
    press(idx);
    m_led = (idx == SW_SHOW_HI) ? m_rd[15:8] : m_rd[7:0];
    check("led_show", 32'(led), 32'(m_led));
  endtask

  task automatic wait_txn(input int f0, input int d0, input int lat);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (falls > f0 && (lat == 0 || busy_done > d0)) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("txn_done", 32'(ok), 32'd1);
    tick(3);
  endtask

  // Issue one request; both_sw also raises the read switch in the same cycle.
  task automatic do_req(input bit is_wr, input int lat, input int blen,
                        input logic [15:0] rdv, input bit both_sw);
    int f0, d0;
    exp_t e;
    mdl_lat  = lat;
    mdl_busy = blen;
    mdl_rd   = rdv;
    e.is_wr  = is_wr;
    e.word   = m_data;
    e.row    = m_row;
    e.width  = (lat == 0) ? AT : lat + 1;
    exp_q.push_back(e);
    f0 = falls;
    d0 = busy_done;
    if (both_sw) begin
      sw[SW_WRITE] = 1'b1;
      sw[SW_READ]  = 1'b1;
      tick(DB + 6);
      sw[SW_WRITE] = 1'b0;
      sw[SW_READ]  = 1'b0;
      tick(DB + 6);
    end else begin
      press(is_wr ? SW_WRITE : SW_READ);
    end
    wait_txn(f0, d0, lat);
    if (lat == 0) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (!is_wr) m_rd = rdv;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, d0;
    bit ok;
    rst = 1'b1;
    sw  = '0;
    dp  = '0;
    tick(3);
    check("rst_write", 32'(write_o), 32'd0);
    check("rst_read",  32'(read_o),  32'd0);
    check("rst_wr_oe", 32'(wr_oe),   32'd0);
    check("rst_err",   32'(err),     32'd0);
    check("rst_led",   32'(led),     32'd0);
    check("rst_row",   32'(row_o),   32'd0);
    check("const_ba",  32'(ba),      32'd0);
    check("const_col", 32'(col_o),   32'd0);
    check("const_wlen", 32'(wlen),   32'd1);
    rst = 1'b0;
    tick(2);

    // Basic write: A53C to row 0x12, BUSY 3 cycles after request for 10 cycles.
    load(SW_LOAD_HI, 8'hA5);
    load(SW_LOAD_LO, 8'h3C);
    load(SW_LOAD_ROW, 8'h12);
    do_req(1'b1, 3, 10, 16'h0000, 1'b0);
    check("fsm_idle_after_wr", 32'(dut.state), 32'(IDLE));
    check("wr_oe_after_wr",    32'(wr_oe),     32'd0);

    // Read returning BEEF, then display both bytes.
    do_req(1'b0, 2, 5, 16'hBEEF, 1'b0);
    show(SW_SHOW_HI);
    show(SW_SHOW_LO);

    // Write and read pressed together: only the write is issued.
    do_req(1'b1, 1, 3, 16'h0000, 1'b1);
    tick(DB + 10);
    check("no_extra_req", 32'(exp_q.size()), 32'd0);

    // Read with no BUSY response times out and sets ERR; a good write clears it.
    do_req(1'b0, 0, 1, 16'h0000, 1'b0);
    check("err_after_timeout", 32'(err), 32'(m_err));
    do_req(1'b1, 4, 2, 16'h0000, 1'b0);
    check("err_cleared", 32'(err), 32'(m_err));

    // Glitching write switch never settles long enough to register.
    f0 = falls;
    repeat (5) begin
      sw[SW_WRITE] = 1'b1;
      tick(3);
      sw[SW_WRITE] = 1'b0;
      tick(2);
    end
    tick(20);
    check("glitch_no_req", 32'(falls), 32'(f0));

    // Reset while waiting for BUSY to fall on a write.
    mdl_lat  = 2;
    mdl_busy = 40;
    begin
      exp_t e;
      e.is_wr = 1'b1;
      e.word  = m_data;
      e.row   = m_row;
      e.width = 3;
      exp_q.push_back(e);
    end
    d0 = busy_done;
    press(SW_WRITE);
    check("wr_oe_in_wait_done", 32'(wr_oe), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_write", 32'(write_o), 32'd0);
    check("rst_mid_wr_oe", 32'(wr_oe),   32'd0);
    check("rst_mid_led",   32'(led),     32'd0);
    rst = 1'b0;
    m_data = '0;
    m_row  = '0;
    m_rd   = '0;
    m_led  = '0;
    m_err  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy_done > d0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("busy_release", 32'(ok), 32'd1);
    tick(3);
    check("fsm_idle_after_rst", 32'(dut.state), 32'(IDLE));

    // Random operation mix against the model.
    for (int n = 0; n < 14; n++) begin
      int kind;
      int lat;
      kind = $urandom_range(0, 6);
      lat  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
      case (kind)
        0: load(SW_LOAD_HI, 8'($urandom));
        1: load(SW_LOAD_LO, 8'($urandom));
        2: load(SW_LOAD_ROW, 8'($urandom));
        3: do_req(1'b1, lat, $urandom_range(1, 6), 16'h0000, 1'b0);
        4: do_req(1'b0, lat, $urandom_range(1, 6), 16'($urandom), 1'b0);
        5: show(SW_SHOW_HI);
        default: show(SW_SHOW_LO);
      endcase
      check("rand_led", 32'(led), 32'(m_led));
      check("rand_err", 32'(err), 32'(m_err));
    end

    check("never_both_req", 32'(both_seen), 32'd0);
    check("queue_drained",  32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
